m_usequencer: RTL and testbench

- Microcode sequencer for midgetv. It generates the registered microcode address minx that feeds the 2-EBR/3-EBR microcode store each cycle.
- It selects the next address from these sources: next-address field rinx, opcode dispatch, conditional branch, trap/interrupt entry and reset entry.
- It freezes the microcode store, via progress_ucode, during memory stalls and multi-cycle shifts.
- It sits between the instruction decoder, the shift logic and the microcode store.

---
 rtl/m_usequencer_if.sv | 34 +++
 rtl/m_usequencer.sv | 111 +++++++++++
 tb/tb_m_usequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/m_usequencer_if.sv
// Bundle of signals between the decoder/shift/condition logic and the microcode sequencer.
// The master drives the request side; the sequencer (slave) returns the address and status.
interface m_usequencer_if #(
  parameter int SHIFT_W = 5
);
  logic [7:0]         rinx;
  logic               dispatch;
  logic [7:0]         dispatch_minx;
  logic               use_brcond;
  logic               brcond;
  logic               stall;
  logic               shift_start;
  logic [SHIFT_W-1:0] shift_amt;
  logic               trap_req;
  logic               irq_req;
  logic               irq_en;
  logic [7:0]         minx;
  logic               progress_ucode;
  logic               shifting;
  logic               trap_ack;
  logic               irq_ack;

  modport master (
    output rinx, dispatch, dispatch_minx, use_brcond, brcond, stall,
           shift_start, shift_amt, trap_req, irq_req, irq_en,
    input  minx, progress_ucode, shifting, trap_ack, irq_ack
  );

  modport slave (
    input  rinx, dispatch, dispatch_minx, use_brcond, brcond, stall,
           shift_start, shift_amt, trap_req, irq_req, irq_en,
    output minx, progress_ucode, shifting, trap_ack, irq_ack
  );
endinterface

// File: rtl/m_usequencer.sv
// Microcode sequencer: selects the next registered microcode address and freezes the
// microcode store during memory stalls and multi-cycle shifts.
module m_usequencer #(
  parameter logic [7:0] RESET_MINX = 8'h00,
  parameter logic [7:0] TRAP_MINX  = 8'hF0,
  parameter logic [7:0] IRQ_MINX   = 8'hF8,
  parameter int         SHIFT_W    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  m_usequencer_if.slave   bus
);
  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_RUN   = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         minx_q, minx_d;
  logic [SHIFT_W-1:0] cnt_q, cnt_d;
  logic               shifting_q, shifting_d;
  logic               trap_ack_q, trap_ack_d;
  logic               irq_ack_q, irq_ack_d;
  logic               trap_pend_q, trap_pend_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RST;
      minx_q      <= RESET_MINX;
      cnt_q       <= '0;
      shifting_q  <= 1'b0;
      trap_ack_q  <= 1'b0;
      irq_ack_q   <= 1'b0;
      trap_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      minx_q      <= minx_d;
      cnt_q       <= cnt_d;
      shifting_q  <= shifting_d;
      trap_ack_q  <= trap_ack_d;
      irq_ack_q   <= irq_ack_d;
      trap_pend_q <= trap_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    minx_d      = minx_q;
    cnt_d       = cnt_q;
    shifting_d  = shifting_q;
    trap_ack_d  = 1'b0;
    irq_ack_d   = 1'b0;
    trap_pend_d = trap_pend_q;

    unique case (state_q)
      ST_RST: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        // A trap deferred from a shift wins over everything on the first RUN cycle.
        if (bus.trap_req || trap_pend_q) begin
          minx_d      = TRAP_MINX;
          trap_ack_d  = 1'b1;
          trap_pend_d = 1'b0;
        end else if (bus.stall) begin
          minx_d = minx_q;
        end else if (bus.irq_req && bus.irq_en && bus.dispatch) begin
          minx_d    = IRQ_MINX;
          irq_ack_d = 1'b1;
        end else if (bus.shift_start && (bus.shift_amt != '0)) begin
          cnt_d      = bus.shift_amt - SHIFT_W'(1);
          state_d    = ST_SHIFT;
          shifting_d = 1'b1;
        end else if (bus.shift_start) begin
          minx_d = bus.rinx;
        end else if (bus.dispatch) begin
          minx_d = bus.dispatch_minx;
        end else if (bus.use_brcond && bus.brcond) begin
          minx_d = {bus.rinx[7:1], 1'b1};
        end else begin
          minx_d = bus.rinx;
        end
      end

      ST_SHIFT: begin
        if (bus.trap_req) begin
          trap_pend_d = 1'b1;
        end
        if (cnt_q == '0) begin
          state_d    = ST_RUN;
          shifting_d = 1'b0;
          minx_d     = bus.rinx;
        end else begin
          cnt_d = cnt_q - SHIFT_W'(1);
        end
      end

      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  assign bus.minx           = minx_q;
  assign bus.shifting       = shifting_q;
  assign bus.trap_ack       = trap_ack_q;
  assign bus.irq_ack        = irq_ack_q;
  assign bus.progress_ucode = (state_q == ST_RUN) && !bus.stall;
endmodule

// File: tb/tb_m_usequencer.sv
// Directed bench for m_usequencer: linear stimulus, immediate-assertion checks.
module tb_m_usequencer;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  m_usequencer_if #(.SHIFT_W(5)) u_if ();

  m_usequencer #(
    .RESET_MINX (8'h00),
    .TRAP_MINX  (8'hF0),
    .IRQ_MINX   (8'hF8),
    .SHIFT_W    (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
    $display("check %-14s observed=%02h expected=%02h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [7:0] m, input logic sh,
                           input logic pu, input logic ta, input logic ia);
    check({tag, ".minx"}, u_if.minx, m);
    check({tag, ".shift"}, {7'd0, u_if.shifting}, {7'd0, sh});
    check({tag, ".prog"}, {7'd0, u_if.progress_ucode}, {7'd0, pu});
    check({tag, ".tack"}, {7'd0, u_if.trap_ack}, {7'd0, ta});
    check({tag, ".iack"}, {7'd0, u_if.irq_ack}, {7'd0, ia});
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    u_if.rinx = 8'h00; u_if.dispatch = 1'b0; u_if.dispatch_minx = 8'h00;
    u_if.use_brcond = 1'b0; u_if.brcond = 1'b0; u_if.stall = 1'b0;
    u_if.shift_start = 1'b0; u_if.shift_amt = 5'd0; u_if.trap_req = 1'b0;
    u_if.irq_req = 1'b0; u_if.irq_en = 1'b0;

    #22;
    chk_state("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_state("rst_exit", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    u_if.rinx = 8'h12;
    step();
    chk_state("advance", 8'h12, 1'b0, 1'b1, 1'b0, 1'b0);

    // Shift of 5: held for 5 cycles, rinx taken on the 6th edge.
    u_if.rinx = 8'h40; u_if.shift_start = 1'b1; u_if.shift_amt = 5'd5;
    step();
    u_if.shift_start = 1'b0;
    chk_state("shift5_0", 8'h12, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 5; i++) begin
      step();
      chk_state($sformatf("shift5_%0d", i), 8'h12, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    step();
    chk_state("shift5_end", 8'h40, 1'b0, 1'b1, 1'b0, 1'b0);

    u_if.rinx = 8'h44; u_if.shift_start = 1'b1; u_if.shift_amt = 5'd0;
    step();
    u_if.shift_start = 1'b0;
    chk_state("shift0", 8'h44, 1'b0, 1'b1, 1'b0, 1'b0);

    // Stall holds minx and blocks dispatch.
    u_if.stall = 1'b1; u_if.dispatch = 1'b1; u_if.dispatch_minx = 8'h80;
    #1;
    check("stall_prog", {7'd0, u_if.progress_ucode}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_state($sformatf("stall_%0d", i), 8'h44, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    u_if.stall = 1'b0;
    step();
    chk_state("stall_disp", 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);

    // Trap beats interrupt; interrupt taken at the next boundary.
    u_if.trap_req = 1'b1; u_if.irq_req = 1'b1; u_if.irq_en = 1'b1;
    step();
    chk_state("trap_irq", 8'hF0, 1'b0, 1'b1, 1'b1, 1'b0);
    u_if.trap_req = 1'b0;
    step();
    chk_state("irq", 8'hF8, 1'b0, 1'b1, 1'b0, 1'b1);
    u_if.irq_en = 1'b0; u_if.dispatch_minx = 8'h33;
    step();
    chk_state("irq_masked", 8'h33, 1'b0, 1'b1, 1'b0, 1'b0);
    u_if.irq_req = 1'b0; u_if.dispatch = 1'b0;

    u_if.use_brcond = 1'b1; u_if.rinx = 8'h2A; u_if.brcond = 1'b1;
    step();
    check("br_taken", u_if.minx, 8'h2B);
    u_if.brcond = 1'b0;
    step();
    check("br_not", u_if.minx, 8'h2A);
    u_if.use_brcond = 1'b0;
    u_if.rinx = 8'hFF;
    step();
    check("wrap", u_if.minx, 8'hFF);

    // Trap arriving mid-shift is deferred to the first RUN cycle.
    u_if.rinx = 8'h50; u_if.shift_start = 1'b1; u_if.shift_amt = 5'd4;
    step();
    u_if.shift_start = 1'b0;
    chk_state("tshift_0", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    u_if.trap_req = 1'b1;
    step();
    u_if.trap_req = 1'b0;
    chk_state("tshift_1", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_state("tshift_2", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_state("tshift_3", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_state("tshift_end", 8'h50, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk_state("tshift_trap", 8'hF0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    chk_state("tshift_after", 8'h50, 1'b0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a shift.
    u_if.rinx = 8'h60; u_if.shift_start = 1'b1; u_if.shift_amt = 5'd10;
    step();
    u_if.shift_start = 1'b0;
    step();
    check("rshift_pre", {7'd0, u_if.shifting}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("rshift_async", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    chk_state("rshift_exit", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check("rshift_run", u_if.minx, 8'h60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
